// File: rtl/display_scan_controller.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 3-digit
// time-multiplexed 7-segment scan with optional leading-zero blanking.
module display_scan_controller #(
    parameter int unsigned REFRESH_CYCLES      = 50000,
    parameter bit          BLANK_LEADING_ZEROS = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] value,
    input  logic       value_valid,
    output logic       value_ready,
    output logic       busy,
    output logic [3:0] binary_number,
    output logic [2:0] digit_select
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_e;

    state_e            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [11:0]       bcd_q, bcd_d, bcd_adj;
    logic [2:0]        iter_q, iter_d;
    logic [3:0]        hund_q, hund_d, tens_q, tens_d, units_q, units_d;
    logic              ready_q, ready_d, busy_q, busy_d;
    logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        bn_q, bn_d;
    logic [2:0]        sel1_q, sel1_d, sel_q, sel_d;
    logic              blank_c;

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: next state and datapath
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        units_d = units_q;
        case (state_q)
            IDLE: begin
                if (value_valid && ready_q) begin
                    shift_d = value;
                    bcd_d   = 12'h000;
                    iter_d  = 3'd0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj[10:0], shift_q, 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                hund_d  = bcd_q[11:8];
                tens_d  = bcd_q[7:4];
                units_d = bcd_q[3:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // Scan: refresh counter, digit index, code and two-stage select pipeline
    always_comb begin
        ref_cnt_d = ref_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
            ref_cnt_d = '0;
            idx_d     = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        blank_c = BLANK_LEADING_ZEROS &&
                  (((idx_q == 2'd2) && (hund_q == 4'd0)) ||
                   ((idx_q == 2'd1) && (hund_q == 4'd0) && (tens_q == 4'd0)));
        case (idx_q)
            2'd1:    begin bn_d = tens_q;  sel1_d = 3'b101; end
            2'd2:    begin bn_d = hund_q;  sel1_d = 3'b011; end
            default: begin bn_d = units_q; sel1_d = 3'b110; end
        endcase
        if (blank_c) begin
            sel1_d = 3'b111;
        end
        sel_d = sel1_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bcd_q     <= 12'h000;
            iter_q    <= 3'd0;
            hund_q    <= 4'd0;
            tens_q    <= 4'd0;
            units_q   <= 4'd0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            ref_cnt_q <= '0;
            idx_q     <= 2'd0;
            bn_q      <= 4'h0;
            sel1_q    <= 3'b111;
            sel_q     <= 3'b111;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            iter_q    <= iter_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            bn_q      <= bn_d;
            sel1_q    <= sel1_d;
            sel_q     <= sel_d;
        end
    end

    assign value_ready   = ready_q;
    assign busy          = busy_q;
    assign binary_number = bn_q;
    assign digit_select  = sel_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: two instances (blanking on/off) driven
// with the same stimulus and compared against a decimal-arithmetic model.
module tb_display_scan_controller;

    localparam int unsigned R = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       value_valid;
    logic [7:0] value;
    logic       ready_b, busy_b, ready_f, busy_f;
    logic [3:0] bn_b, bn_f;
    logic [2:0] ds_b, ds_f;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: edge count since reset release, busy window end, pending commit
    int e, busy_end, commit_edge, pend_val;
    int comm_hist[8192];
    bit accepted;

    always #5 clock = ~clock;

    display_scan_controller #(.REFRESH_CYCLES(R), .BLANK_LEADING_ZEROS(1'b1)) u_blank (
        .clock(clock), .reset_n(reset_n), .value(value), .value_valid(value_valid),
        .value_ready(ready_b), .busy(busy_b), .binary_number(bn_b), .digit_select(ds_b)
    );

    display_scan_controller #(.REFRESH_CYCLES(R), .BLANK_LEADING_ZEROS(1'b0)) u_full (
        .clock(clock), .reset_n(reset_n), .value(value), .value_valid(value_valid),
        .value_ready(ready_f), .busy(busy_f), .binary_number(bn_f), .digit_select(ds_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t edge %0d: got %0d expected %0d", tag, $time, e, got, exp);
        end
    endtask

    function automatic int digit_of(input int v, input int i);
        if (i == 0) return v % 10;
        if (i == 1) return (v / 10) % 10;
        return v / 100;
    endfunction

    function automatic int sel_of(input int v, input int i, input bit blank);
        if (blank && i == 2 && v < 100) return 7;
        if (blank && i == 1 && v < 10) return 7;
        return (~(1 << i)) & 7;
    endfunction

    function automatic int idx_at(input int k);
        return (k / R) % 3;
    endfunction

    task automatic check_outputs();
        int exp_bn, exp_ds_b, exp_ds_f, exp_busy;
        exp_bn   = (e >= 1) ? digit_of(comm_hist[e-1], idx_at(e-1)) : 0;
        exp_ds_b = (e >= 2) ? sel_of(comm_hist[e-2], idx_at(e-2), 1'b1) : 7;
        exp_ds_f = (e >= 2) ? sel_of(comm_hist[e-2], idx_at(e-2), 1'b0) : 7;
        exp_busy = (e < busy_end) ? 1 : 0;
        check("busy_b",  32'(busy_b),  32'(exp_busy));
        check("ready_b", 32'(ready_b), 32'(1 - exp_busy));
        check("busy_f",  32'(busy_f),  32'(exp_busy));
        check("ready_f", 32'(ready_f), 32'(1 - exp_busy));
        check("code_b",  32'(bn_b),    32'(exp_bn));
        check("code_f",  32'(bn_f),    32'(exp_bn));
        check("sel_b",   32'(ds_b),    32'(exp_ds_b));
        check("sel_f",   32'(ds_f),    32'(exp_ds_f));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},  32'(busy_b | busy_f), 32'(0));
        check({tag, "_ready"}, 32'(ready_b & ready_f), 32'(1));
        check({tag, "_code_b"}, 32'(bn_b), 32'(0));
        check({tag, "_code_f"}, 32'(bn_f), 32'(0));
        check({tag, "_sel_b"}, 32'(ds_b), 32'(7));
        check({tag, "_sel_f"}, 32'(ds_f), 32'(7));
    endtask

    task automatic model_init();
        e            = 0;
        busy_end     = 0;
        commit_edge  = -1;
        pend_val     = 0;
        comm_hist[0] = 0;
    endtask

    task automatic step();
        @(posedge clock);
        e++;
        accepted = 1'b0;
        if (e >= 8191) begin
            $display("FAIL model_overflow: got %0d expected below 8191", e);
            $fatal(1);
        end
        if (value_valid && (e - 1) >= busy_end) begin
            accepted    = 1'b1;
            busy_end    = e + 9;
            commit_edge = e + 9;
            pend_val    = int'(value);
        end
        comm_hist[e] = (e == commit_edge) ? pend_val : comm_hist[e-1];
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int v);
        value       = 8'(v);
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
    endtask

    task automatic finish_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("in_reset");
        @(negedge clock);
        reset_n = 1'b1;
        model_init();
    endtask

    initial begin
        int guard;
        reset_n     = 1'b0;
        value_valid = 1'b0;
        value       = 8'h00;
        model_init();
        finish_reset();

        run(30);
        pulse(255);
        run(30);
        pulse(7);
        run(2);
        pulse(40);
        run(30);
        pulse(100);
        run(30);
        pulse(9);
        run(30);

        // Asynchronous reset in the middle of a conversion
        pulse(123);
        run(20);
        pulse(200);
        run(4);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        finish_reset();
        run(20);

        for (int i = 0; i < 400; i++) begin
            value       = 8'($urandom_range(0, 255));
            value_valid = ($urandom_range(0, 3) == 0);
            step();
        end
        value_valid = 1'b0;
        run(12);

        // Back-to-back sweep with value_valid held high
        value_valid = 1'b1;
        for (int v = 0; v < 256; v++) begin
            value = 8'(v);
            guard = 0;
            accepted = 1'b0;
            while (!accepted && guard < 20) begin
                step();
                guard++;
            end
            if (!accepted) check("sweep_accept", 32'(0), 32'(1));
        end
        value_valid = 1'b0;
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Upstream feeder for the 7-segment binary-to-segment decoder. Accepts an 8-bit sensor reading (0-255) and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) converter.
- Time-multiplexes the digits onto a single 4-bit digit-code bus, with active-low digit selects for a 3-digit common-anode display.
- Digit selects are delayed one cycle so they align with the decoder's registered segment outputs.

Parameters:
- REFRESH_CYCLES, 50000: clock cycles each digit stays lit (1 ms at 50 MHz). Minimum 2.
- BLANK_LEADING_ZEROS, 1: 1 blanks leading-zero hundreds/tens digits; 0 always shows all three.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- value  input  8  binary reading to display
- value_valid  input  1  load strobe; accepted only when value_ready=1
- value_ready  output  1  high when idle and able to accept a value
- busy  output  1  conversion in progress (equals ~value_ready)
- binary_number  output  4  BCD code of the currently scanned digit, to the decoder
- digit_select  output  3  active-low one-hot digit enable: [0]=units, [1]=tens, [2]=hundreds; delayed 1 cycle vs binary_number

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous and active-low.
- Reset values:
  - state IDLE, value_ready=1, busy=0
  - shift/BCD registers 0, committed digits 0/0/0
  - refresh counter 0, digit index 0
  - binary_number=4'h0, digit_select=3'b111
- Reset mid-conversion aborts it with no commit. The display returns to "0" (units only when blanking is on).
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: on the edge where value_valid && value_ready, load shift_reg<=value, clear bcd<=12'h000 and iter<=0, go to CONVERT.
  - CONVERT: each cycle, every BCD nibble >=5 gets +3, then {bcd,shift_reg} shifts left by 1. iter increments. After the iter==7 pass, go to COMMIT (8 cycles total).
  - COMMIT: copy bcd into the committed hundreds/tens/units registers in one cycle, return to IDLE.
- Latency and busy:
  - Value accepted at edge N; committed digits update at edge N+9.
  - busy=1 from after edge N through edge N+9 (9 cycles). value_ready=0 over the same interval.
- value_valid while busy is ignored, with no queueing and no error. value_valid held high re-loads at the first idle cycle.
- Arithmetic: hundreds max 2. Nibbles never exceed 9 after commit. Internal BCD is 12 bits wide.
- Scanning:
  - Free-running refresh counter counts 0..REFRESH_CYCLES-1.
  - On wrap, digit index advances 0→1→2→0 (index 3 is never reached).
  - Scanning is independent of conversion; old digits stay displayed until COMMIT.
  - A commit takes effect on the next cycle's binary_number. There is no forced re-sync of the scan.
- binary_number is registered: the committed digit of the current index.
- digit_select is built in two steps:
  - Registered stage 1: one-hot active-low for the index (units 3'b110, tens 3'b101, hundreds 3'b011), or 3'b111 if blanked.
  - Stage 2: registered again, so it is valid in the same cycle as the decoder's segment outputs.
- Blanking (BLANK_LEADING_ZEROS=1):
  - Hundreds is blanked when hundreds==0.
  - Tens is blanked when hundreds==0 && tens==0.
  - Units is never blanked.
  - While blanked, binary_number still shows the digit code; only the select is suppressed.
- Simultaneous events: a commit landing on a refresh wrap uses the new digits for the newly selected index.

Test Plan:
- Reset release, then 30 idle cycles (REFRESH_CYCLES=4, blanking on) → busy=0, value_ready=1, binary_number=0. digit_select shows 3'b110 when units is selected and 3'b111 during the tens and hundreds slots.
- value=8'd255, valid pulse at edge N → busy high for 9 cycles. Committed digits 2/5/5 at N+9. Scan shows codes 5, 5, 2 with selects 3'b110, 3'b101, 3'b011 (selects one cycle after codes).
- value=8'd7, then value=8'd40 pulsed at cycle N+3 → second load ignored. Display shows 0/0/7 with tens and hundreds blanked (3'b111).
- value=8'd100 with BLANK_LEADING_ZEROS=0 → digits 1/0/0, all three selects asserted in turn. value=8'd9 → 0/0/9 with all three selects still asserted.
- reset_n asserted asynchronously mid-CONVERT (iter=4) after a prior commit of 123 → outputs return to reset values immediately. No commit occurs; the display shows 0.
- Sweep all 256 values back-to-back with value_valid held high → each commit equals the decimal value. Exactly 10 cycles per value (9 busy + 1 idle accept).
